park_lane_scheduler: RTL and testbench

- Controller for a single shared gate lane of the car park. The lane has an entry bar and an exit bar, and only one car uses the lane at a time.
- It arbitrates between entry and exit requesters, allocates parking tickets from a free-slot pool, and timestamps each entry.
- It bills exits from a prescaled time base, waits for payment, and times bar openings in clock cycles (no delays).
- It sits between the sensor/payment front end and the bar actuators, and it owns the occupancy count.

---
 rtl/park_lane_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_park_lane_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_lane_scheduler.sv
// Shared entry/exit gate lane controller for the car park.
// Arbitrates entry and exit requests, issues tickets from a free-slot bitmap,
// timestamps entries against a prescaled time base, bills exits and times the
// bar openings in clock cycles.
//
// state      | meaning
// IDLE       | lane free, arbitrating entry/exit requests
// ENTRY_OPEN | entry bar open for BAR_TICKS cycles
// EXIT_BILL  | cost presented, waiting for the pay pulse
// EXIT_OPEN  | exit bar open for BAR_TICKS cycles
module park_lane_scheduler #(
  parameter int PMAX      = 5,
  parameter int IDW       = 3,
  parameter int BAR_TICKS = 5000,
  parameter int TICK_DIV  = 1000,
  parameter int TW        = 16,
  parameter int RATE      = 1,
  parameter int CW        = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sin,
  input  logic           sout,
  input  logic [IDW-1:0] exit_id,
  input  logic           pay,
  output logic           bin,
  output logic           bout,
  output logic [IDW-1:0] entry_id,
  output logic           entry_id_valid,
  output logic [CW-1:0]  cost,
  output logic           cost_valid,
  output logic           id_err,
  output logic [IDW:0]   free,
  output logic           full
);

  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BTW = (BAR_TICKS > 1) ? $clog2(BAR_TICKS) : 1;
  localparam int PW  = TW + 32;

  // last_grant encoding: 0 = entry was granted last, 1 = exit was granted last
  localparam logic LG_ENTRY = 1'b0;
  localparam logic LG_EXIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_BILL  = 2'd2,
    EXIT_OPEN  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [PMAX-1:0] occ;
  logic [TW-1:0]   ts [PMAX];
  logic [TW-1:0]   now;
  logic [PSW-1:0]  pscl;
  logic [BTW-1:0]  bar_tmr;
  logic            last_grant;
  logic [IDW-1:0]  cur_id;

  logic            ent_req;
  logic            grant_ent;
  logic            grant_ext;
  logic            exit_hit;
  logic            bar_load;
  logic [IDW-1:0]  alloc_id;
  logic [TW-1:0]   ts_sel;
  logic [TW-1:0]   elapsed;
  logic [PW-1:0]   prod;
  logic [CW-1:0]   cost_nx;

  assign full    = (free == '0);
  assign ent_req = sin && !full;

  // Round-robin: on a tie the requester that did not win last time is served.
  assign grant_ent = (state == IDLE) && ent_req && (!sout || last_grant == LG_EXIT);
  assign grant_ext = (state == IDLE) && sout && !grant_ent;
  assign bar_load  = grant_ent || (grant_ext && exit_hit) || (state == EXIT_BILL && pay);

  // Slot allocation, ticket lookup and saturating bill computation.
  always_comb begin
    alloc_id = '0;
    for (int i = PMAX - 1; i >= 0; i--) begin
      if (!occ[i]) alloc_id = IDW'(i);
    end
    exit_hit = 1'b0;
    ts_sel   = '0;
    for (int i = 0; i < PMAX; i++) begin
      if (exit_id == IDW'(i)) begin
        exit_hit = occ[i];
        ts_sel   = ts[i];
      end
    end
    elapsed = now - ts_sel;
    prod    = PW'(elapsed) * PW'(RATE);
    cost_nx = ((prod >> CW) != '0) ? {CW{1'b1}} : CW'(prod);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_ent)                  state_nx = ENTRY_OPEN;
        else if (grant_ext && exit_hit) state_nx = EXIT_BILL;
      end
      ENTRY_OPEN: if (bar_tmr == '0) state_nx = IDLE;
      EXIT_BILL:  if (pay)           state_nx = EXIT_OPEN;
      EXIT_OPEN:  if (bar_tmr == '0) state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  // Bar actuators follow the state directly so they drop the cycle the FSM leaves.
  always_comb begin
    bin  = (state == ENTRY_OPEN);
    bout = (state == EXIT_OPEN);
  end

  // Time base, bar timer, ticket pool, billing registers and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pscl           <= '0;
      now            <= '0;
      bar_tmr        <= '0;
      occ            <= '0;
      free           <= (IDW+1)'(PMAX);
      last_grant     <= LG_EXIT;
      cur_id         <= '0;
      entry_id       <= '0;
      entry_id_valid <= 1'b0;
      cost           <= '0;
      cost_valid     <= 1'b0;
      id_err         <= 1'b0;
      for (int i = 0; i < PMAX; i++) ts[i] <= '0;
    end else begin
      if (pscl == PSW'(TICK_DIV - 1)) begin
        pscl <= '0;
        now  <= now + TW'(1);
      end else begin
        pscl <= pscl + PSW'(1);
      end

      if (bar_load)            bar_tmr <= BTW'(BAR_TICKS - 1);
      else if (bar_tmr != '0)  bar_tmr <= bar_tmr - BTW'(1);

      entry_id_valid <= 1'b0;
      id_err         <= 1'b0;

      if (grant_ent) begin
        for (int i = 0; i < PMAX; i++) begin
          if (alloc_id == IDW'(i)) begin
            occ[i] <= 1'b1;
            ts[i]  <= now;
          end
        end
        free           <= free - (IDW+1)'(1);
        entry_id       <= alloc_id;
        entry_id_valid <= 1'b1;
        last_grant     <= LG_ENTRY;
      end

      if (grant_ext) begin
        if (exit_hit) begin
          cur_id     <= exit_id;
          cost       <= cost_nx;
          cost_valid <= 1'b1;
          last_grant <= LG_EXIT;
        end else begin
          id_err     <= 1'b1;
        end
      end

      if (state == EXIT_BILL && pay) begin
        for (int i = 0; i < PMAX; i++) begin
          if (cur_id == IDW'(i)) occ[i] <= 1'b0;
        end
        free       <= free + (IDW+1)'(1);
        cost_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_park_lane_scheduler.sv
// Scoreboard bench for park_lane_scheduler: expected ticket IDs and bills are
// queued when a request is driven and compared when the DUT presents them.
module tb_park_lane_scheduler;

  localparam int PMAX = 2, IDW = 2, BAR_TICKS = 4, TICK_DIV = 2, RATE = 3, TW = 8, CW = 8;

  logic           clk = 1'b0, rst = 1'b1, sin = 1'b0, sout = 1'b0, pay = 1'b0;
  logic [IDW-1:0] exit_id = '0;
  logic           bin, bout, entry_id_valid, cost_valid, id_err, full;
  logic [IDW-1:0] entry_id;
  logic [CW-1:0]  cost;
  logic [IDW:0]   free;

  int n_checks = 0, n_errors = 0;
  int tb_k = 0;
  int occ_m [PMAX];
  int ts_m  [PMAX];
  int last_m;
  int exp_id_q [$];
  int exp_cost_q [$];
  int n_iderr = 0;
  logic cv_prev = 1'b0;

  park_lane_scheduler #(
    .PMAX(PMAX), .IDW(IDW), .BAR_TICKS(BAR_TICKS), .TICK_DIV(TICK_DIV),
    .TW(TW), .RATE(RATE), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .sin(sin), .sout(sout), .exit_id(exit_id), .pay(pay),
    .bin(bin), .bout(bout), .entry_id(entry_id), .entry_id_valid(entry_id_valid),
    .cost(cost), .cost_valid(cost_valid), .id_err(id_err), .free(free), .full(full)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; drives the model of the time base.
  always @(posedge clk) begin
    if (rst) tb_k <= 0;
    else     tb_k <= tb_k + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int now_m();
    return (tb_k / TICK_DIV) % (1 << TW);
  endfunction

  function automatic int model_free();
    int f = PMAX;
    for (int i = 0; i < PMAX; i++) f -= occ_m[i];
    return f;
  endfunction

  function automatic int cost_m(input int xid);
    int e = (now_m() - ts_m[xid]) & ((1 << TW) - 1);
    int c = e * RATE;
    return (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
  endfunction

  // Monitor: bar exclusion, ticket and bill scoreboards, id_err pulse count.
  always @(negedge clk) begin : mon
    int e;
    if (!rst) begin
      if (bin || bout) check_eq("bar_mutex", int'(bin && bout), 0);
      if (entry_id_valid) begin
        if (exp_id_q.size() == 0) check_eq("entry_unexpected", 1, 0);
        else begin
          e = exp_id_q.pop_front();
          check_eq("entry_id", int'(entry_id), e);
        end
      end
      if (cost_valid && !cv_prev) begin
        if (exp_cost_q.size() == 0) check_eq("cost_unexpected", 1, 0);
        else begin
          e = exp_cost_q.pop_front();
          check_eq("cost", int'(cost), e);
        end
      end
      if (id_err) n_iderr++;
    end
    cv_prev <= cost_valid;
  end

  task automatic ent_push();
    int id = -1;
    for (int i = PMAX - 1; i >= 0; i--) if (occ_m[i] == 0) id = i;
    exp_id_q.push_back(id);
    occ_m[id] = 1;
    ts_m[id]  = now_m();
    last_m    = 0;
  endtask

  task automatic ext_push(input int xid);
    exp_cost_q.push_back(cost_m(xid));
    last_m = 1;
  endtask

  task automatic bar_len(input string tag, input bit which);
    int n = 0;
    while (((which ? bout : bin) == 1'b1) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq(tag, n, BAR_TICKS);
  endtask

  task automatic do_entry(input string tag);
    sin = 1'b1;
    ent_push();
    @(negedge clk);
    sin = 1'b0;
    bar_len({tag, "_bin_len"}, 1'b0);
    check_eq({tag, "_free"}, int'(free), model_free());
  endtask

  task automatic exit_start(input int xid);
    sout = 1'b1;
    exit_id = IDW'(xid);
    ext_push(xid);
    @(negedge clk);
    sout = 1'b0;
    check_eq("exit_cost_valid", int'(cost_valid), 1);
    check_eq("exit_bout_low", int'(bout), 0);
  endtask

  task automatic pay_open(input int xid);
    check_eq("cv_hold", int'(cost_valid), 1);
    pay = 1'b1;
    @(negedge clk);
    pay = 1'b0;
    occ_m[xid] = 0;
    check_eq("cv_clear", int'(cost_valid), 0);
    bar_len("bout_len", 1'b1);
    check_eq("exit_free", int'(free), model_free());
  endtask

  task automatic do_exit(input int xid);
    exit_start(xid);
    repeat (3) @(negedge clk);
    check_eq("bill_wait_bout_low", int'(bout), 0);
    pay_open(xid);
  endtask

  task automatic do_tie(input int xid);
    sin = 1'b1;
    sout = 1'b1;
    exit_id = IDW'(xid);
    if (last_m == 1) begin
      ent_push();
      @(negedge clk);
      sin = 1'b0;
      check_eq("tie_entry_first_cv", int'(cost_valid), 0);
      bar_len("tie_entry_first_bin_len", 1'b0);
      ext_push(xid);
      @(negedge clk);
      sout = 1'b0;
      check_eq("tie_exit_second_cv", int'(cost_valid), 1);
      pay_open(xid);
    end else begin
      ext_push(xid);
      @(negedge clk);
      sout = 1'b0;
      check_eq("tie_exit_first_cv", int'(cost_valid), 1);
      check_eq("tie_exit_first_no_bin", int'(bin), 0);
      pay_open(xid);
      ent_push();
      @(negedge clk);
      sin = 1'b0;
      bar_len("tie_entry_second_bin_len", 1'b0);
    end
    check_eq("tie_free", int'(free), model_free());
  endtask

  task automatic id_err_case(input string tag, input int xid);
    int f0 = int'(free);
    int k0 = n_iderr;
    sout = 1'b1;
    exit_id = IDW'(xid);
    @(negedge clk);
    sout = 1'b0;
    check_eq({tag, "_pulse"}, int'(id_err), 1);
    @(negedge clk);
    check_eq({tag, "_pulse_end"}, int'(id_err), 0);
    check_eq({tag, "_no_bill"}, int'(cost_valid), 0);
    check_eq({tag, "_no_bar"}, int'(bin || bout), 0);
    check_eq({tag, "_free"}, int'(free), f0);
    @(negedge clk);
    check_eq({tag, "_count"}, n_iderr - k0, 1);
  endtask

  task automatic wait_now(input int target);
    int g = 0;
    while (now_m() != target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check_eq("wait_now_timeout", g, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, t0;
    for (int i = 0; i < PMAX; i++) begin
      occ_m[i] = 0;
      ts_m[i]  = 0;
    end
    last_m = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_bin", int'(bin), 0);
    check_eq("rst_bout", int'(bout), 0);
    check_eq("rst_entry_valid", int'(entry_id_valid), 0);
    check_eq("rst_cost_valid", int'(cost_valid), 0);
    check_eq("rst_id_err", int'(id_err), 0);
    check_eq("rst_entry_id", int'(entry_id), 0);
    check_eq("rst_cost", int'(cost), 0);
    check_eq("rst_free", int'(free), PMAX);
    check_eq("rst_full", int'(full), 0);

    do_entry("entry_a");
    do_entry("entry_b");
    check_eq("full_flag", int'(full), 1);

    // Entry request held while full must be ignored.
    sin = 1'b1;
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (bin) nb++;
    end
    sin = 1'b0;
    check_eq("full_no_bin", nb, 0);
    check_eq("full_free", int'(free), 0);
    check_eq("full_no_err", n_iderr, 0);

    repeat (20) @(negedge clk);
    do_exit(0);

    do_tie(1);
    do_exit(0);
    do_entry("entry_c");
    do_tie(0);
    do_tie(0);

    id_err_case("iderr_range", 3);
    id_err_case("iderr_empty", 1);

    // Pay outside EXIT_BILL is ignored.
    pay = 1'b1;
    @(negedge clk);
    pay = 1'b0;
    @(negedge clk);
    check_eq("stray_pay_free", int'(free), model_free());
    check_eq("stray_pay_bout", int'(bout), 0);

    // Timestamp wrap: entry at now = 250, exit at now = 4.
    wait_now(250);
    do_entry("entry_wrap");
    wait_now(4);
    exit_start(1);
    check_eq("wrap_cost", int'(cost), 30);
    pay_open(1);

    // Saturation: 100 elapsed units at rate 3 clips to 255.
    t0 = now_m();
    do_entry("entry_sat");
    wait_now((t0 + 100) % 256);
    exit_start(1);
    check_eq("sat_cost", int'(cost), 255);
    pay_open(1);

    // Reset during EXIT_OPEN with another car still parked.
    do_entry("entry_pre_rst");
    exit_start(0);
    pay = 1'b1;
    @(negedge clk);
    pay = 1'b0;
    check_eq("pre_rst_bout", int'(bout), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < PMAX; i++) occ_m[i] = 0;
    last_m = 1;
    check_eq("midrst_bout", int'(bout), 0);
    check_eq("midrst_bin", int'(bin), 0);
    check_eq("midrst_free", int'(free), PMAX);
    check_eq("midrst_full", int'(full), 0);
    check_eq("midrst_cost", int'(cost), 0);
    check_eq("midrst_cost_valid", int'(cost_valid), 0);
    id_err_case("midrst_bitmap", 1);
    do_entry("entry_post_rst");

    check_eq("id_queue_empty", exp_id_q.size(), 0);
    check_eq("cost_queue_empty", exp_cost_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
